// File: rtl/lab2_xcel_partition_engine.sv
// Lomuto quicksort partition engine over 32-bit words in memory, one outstanding request.
// Optional swap counter and resp_swaps port under `LAB2_XCEL_PARTITION_STATS_EN.

package lab2_xcel_partition_pkg;
  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;
endpackage

module lab2_xcel_partition_engine
  import lab2_xcel_partition_pkg::*;
#(
  parameter int unsigned IDX_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_val,
  output logic             cmd_rdy,
  input  logic [31:0]      cmd_base,
  input  logic [IDX_W-1:0] cmd_lo,
  input  logic [IDX_W-1:0] cmd_hi,
  input  logic             cmd_signed,
  input  logic             cmd_desc,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [IDX_W-1:0] resp_idx,
`ifdef LAB2_XCEL_PARTITION_STATS_EN
  output logic [IDX_W-1:0] resp_swaps,
`endif
  output mem_req_4B_t      mem_reqstream_msg,
  output logic             mem_reqstream_val,
  input  logic             mem_reqstream_rdy,
  input  mem_resp_4B_t     mem_respstream_msg,
  input  logic             mem_respstream_val,
  output logic             mem_respstream_rdy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_P = 3'd1;
  localparam logic [2:0] S_RD_J = 3'd2;
  localparam logic [2:0] S_RD_I = 3'd3;
  localparam logic [2:0] S_WR_I = 3'd4;
  localparam logic [2:0] S_WR_J = 3'd5;
  localparam logic [2:0] S_RESP = 3'd6;

  localparam logic [IDX_W-1:0] ONE = 1;

  logic [2:0]       state_q, state_d;
  logic             wait_q, wait_d;
  logic             fin_q, fin_d;
  logic             sgn_q, sgn_d;
  logic             desc_q, desc_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      p_q, p_d;
  logic [31:0]      aj_q, aj_d;
  logic [31:0]      ai_q, ai_d;
  logic [IDX_W-1:0] hi_q, hi_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] swaps_q, swaps_d;

  logic             is_mem, is_wr, bef, adv;
  logic [31:0]      rdata;
  logic [IDX_W-1:0] i_nx, j_inc, k_idx;
  logic             unused_resp_bits;

  assign is_mem = (state_q == S_RD_P) || (state_q == S_RD_J) || (state_q == S_RD_I) ||
                  (state_q == S_WR_I) || (state_q == S_WR_J);
  assign is_wr  = (state_q == S_WR_I) || (state_q == S_WR_J);

  assign cmd_rdy            = (state_q == S_IDLE);
  assign resp_val           = (state_q == S_RESP);
  assign resp_idx           = idx_q;
  assign mem_reqstream_val  = is_mem && !wait_q;
  assign mem_respstream_rdy = is_mem && wait_q;
  assign unused_resp_bits   = ^{mem_respstream_msg.type_, mem_respstream_msg.opaque,
                                mem_respstream_msg.test, mem_respstream_msg.len};
`ifdef LAB2_XCEL_PARTITION_STATS_EN
  assign resp_swaps = swaps_q;
`endif

  always_comb begin
    case (state_q)
      S_RD_P:         k_idx = hi_q;
      S_RD_J:         k_idx = j_q;
      S_RD_I, S_WR_I: k_idx = i_q;
      S_WR_J:         k_idx = fin_q ? hi_q : j_q;
      default:        k_idx = '0;
    endcase
    mem_reqstream_msg        = '0;
    mem_reqstream_msg.type_  = is_wr ? MEM_TYPE_WRITE : MEM_TYPE_READ;
    mem_reqstream_msg.addr   = base_q + (32'(k_idx) << 2);
    if (state_q == S_WR_I)
      mem_reqstream_msg.data = fin_q ? p_q : aj_q;
    else if (state_q == S_WR_J)
      mem_reqstream_msg.data = ai_q;
  end

  always_comb begin
    rdata = mem_respstream_msg.data;
    if (desc_q)
      bef = sgn_q ? ($signed(rdata) > $signed(p_q)) : (rdata > p_q);
    else
      bef = sgn_q ? ($signed(rdata) < $signed(p_q)) : (rdata < p_q);
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fin_d   = fin_q;
    sgn_d   = sgn_q;
    desc_d  = desc_q;
    base_d  = base_q;
    p_d     = p_q;
    aj_d    = aj_q;
    ai_d    = ai_q;
    hi_d    = hi_q;
    i_d     = i_q;
    j_d     = j_q;
    idx_d   = idx_q;
    swaps_d = swaps_q;
    adv     = 1'b0;
    i_nx    = i_q;
    j_inc   = j_q + ONE;
    case (state_q)
      S_IDLE: begin
        if (cmd_val) begin
          base_d  = cmd_base;
          hi_d    = cmd_hi;
          i_d     = cmd_lo;
          j_d     = cmd_lo;
          sgn_d   = cmd_signed;
          desc_d  = cmd_desc;
          fin_d   = 1'b0;
          wait_d  = 1'b0;
          swaps_d = '0;
          if (cmd_lo >= cmd_hi) begin
            idx_d   = cmd_lo;
            state_d = S_RESP;
          end else begin
            state_d = S_RD_P;
          end
        end
      end
      S_RESP: if (resp_rdy) state_d = S_IDLE;
      S_RD_P, S_RD_J, S_RD_I, S_WR_I, S_WR_J: begin
        if (!wait_q) begin
          if (mem_reqstream_rdy) wait_d = 1'b1;
        end else if (mem_respstream_val) begin
          wait_d = 1'b0;
          case (state_q)
            S_RD_P: begin
              p_d     = rdata;
              state_d = S_RD_J;
            end
            S_RD_J: begin
              aj_d = rdata;
              if (bef && (i_q != j_q)) begin
                state_d = S_RD_I;
              end else begin
                adv  = 1'b1;
                i_nx = bef ? i_q + ONE : i_q;
              end
            end
            S_RD_I: begin
              ai_d    = rdata;
              state_d = S_WR_I;
            end
            S_WR_I: state_d = S_WR_J;
            default: begin
              swaps_d = swaps_q + ONE;
              if (fin_q) begin
                idx_d   = i_q;
                state_d = S_RESP;
              end else begin
                adv  = 1'b1;
                i_nx = i_q + ONE;
              end
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Loop exit is an equality test on j+1 so hi = all-ones never relies on wraparound.
    if (adv) begin
      i_d = i_nx;
      if (j_inc == hi_q) begin
        if (i_nx != hi_q) begin
          fin_d   = 1'b1;
          state_d = S_RD_I;
        end else begin
          idx_d   = i_nx;
          state_d = S_RESP;
        end
      end else begin
        j_d     = j_inc;
        state_d = S_RD_J;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= 1'b0;
      fin_q   <= 1'b0;
      sgn_q   <= 1'b0;
      desc_q  <= 1'b0;
      base_q  <= '0;
      p_q     <= '0;
      aj_q    <= '0;
      ai_q    <= '0;
      hi_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      idx_q   <= '0;
      swaps_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fin_q   <= fin_d;
      sgn_q   <= sgn_d;
      desc_q  <= desc_d;
      base_q  <= base_d;
      p_q     <= p_d;
      aj_q    <= aj_d;
      ai_q    <= ai_d;
      hi_q    <= hi_d;
      i_q     <= i_d;
      j_q     <= j_d;
      idx_q   <= idx_d;
      swaps_q <= swaps_d;
    end
  end

endmodule

// File: tb/tb_lab2_xcel_partition_engine.sv
// Directed bench for lab2_xcel_partition_engine with a 1-cycle / randomly stalling memory model.
module tb_lab2_xcel_partition_engine;
  import lab2_xcel_partition_pkg::*;

  localparam int unsigned IDX_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             cmd_val, cmd_rdy, cmd_signed, cmd_desc;
  logic [31:0]      cmd_base;
  logic [IDX_W-1:0] cmd_lo, cmd_hi;
  logic             resp_val, resp_rdy;
  logic [IDX_W-1:0] resp_idx;
`ifdef LAB2_XCEL_PARTITION_STATS_EN
  logic [IDX_W-1:0] resp_swaps;
`endif
  mem_req_4B_t      mem_reqstream_msg;
  logic             mem_reqstream_val, mem_reqstream_rdy;
  mem_resp_4B_t     mem_respstream_msg;
  logic             mem_respstream_val, mem_respstream_rdy;

  lab2_xcel_partition_engine #(.IDX_W(IDX_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_base(cmd_base),
    .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_signed(cmd_signed), .cmd_desc(cmd_desc),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_idx(resp_idx),
`ifdef LAB2_XCEL_PARTITION_STATS_EN
    .resp_swaps(resp_swaps),
`endif
    .mem_reqstream_msg(mem_reqstream_msg), .mem_reqstream_val(mem_reqstream_val),
    .mem_reqstream_rdy(mem_reqstream_rdy),
    .mem_respstream_msg(mem_respstream_msg), .mem_respstream_val(mem_respstream_val),
    .mem_respstream_rdy(mem_respstream_rdy)
  );

  // Memory model: 64 words at byte address 0x1000, index taken modulo 64.
  logic [31:0] mem [64];
  int unsigned req_cnt = 0;
  int unsigned stab_viol = 0;
  bit          stall_en = 1'b0;
  logic        rsp_pend, prev_stall;
  mem_req_4B_t prev_msg;
  logic [5:0]  widx;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_respstream_val <= 1'b0;
      mem_respstream_msg <= '0;
      mem_reqstream_rdy  <= 1'b1;
      rsp_pend   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(mem_reqstream_val === 1'b1 && mem_reqstream_msg === prev_msg))
        stab_viol++;
      prev_stall = mem_reqstream_val && !mem_reqstream_rdy;
      prev_msg   = mem_reqstream_msg;
      if (mem_respstream_val && mem_respstream_rdy) begin
        mem_respstream_val <= 1'b0;
        rsp_pend = 1'b0;
      end else if (rsp_pend && !mem_respstream_val) begin
        mem_respstream_val <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (mem_reqstream_val && mem_reqstream_rdy) begin
        req_cnt++;
        widx = 6'((mem_reqstream_msg.addr - 32'h1000) >> 2);
        mem_respstream_msg       <= '0;
        mem_respstream_msg.type_ <= mem_reqstream_msg.type_;
        if (mem_reqstream_msg.type_ == MEM_TYPE_WRITE) begin
          mem[widx] = mem_reqstream_msg.data;
          mem_respstream_msg.data <= 32'h0;
        end else begin
          mem_respstream_msg.data <= mem[widx];
        end
        rsp_pend = 1'b1;
        mem_respstream_val <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      mem_reqstream_rdy <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int unsigned n_assert = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load5(input logic [31:0] a0, a1, a2, a3, a4);
    mem[0] = a0; mem[1] = a1; mem[2] = a2; mem[3] = a3; mem[4] = a4;
  endtask

  task automatic check5(input string tag, input logic [31:0] a0, a1, a2, a3, a4);
    check({tag, "_m0"}, mem[0], a0);
    check({tag, "_m1"}, mem[1], a1);
    check({tag, "_m2"}, mem[2], a2);
    check({tag, "_m3"}, mem[3], a3);
    check({tag, "_m4"}, mem[4], a4);
  endtask

  task automatic run_cmd(input logic [IDX_W-1:0] lo, input logic [IDX_W-1:0] hi,
                         input bit sgn, input bit desc,
                         output logic [IDX_W-1:0] idx, output int cyc,
                         output int nreq, output logic [IDX_W-1:0] swp);
    int unsigned r0;
    r0 = req_cnt;
    @(negedge clk);
    cmd_base = 32'h1000; cmd_lo = lo; cmd_hi = hi; cmd_signed = sgn; cmd_desc = desc;
    cmd_val = 1'b1;
    @(posedge clk);
    #1 cmd_val = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_val && cyc < 5000);
    check("resp_arrives", {31'd0, resp_val}, 32'd1);
    idx  = resp_idx;
    nreq = int'(req_cnt - r0);
`ifdef LAB2_XCEL_PARTITION_STATS_EN
    swp = resp_swaps;
`else
    swp = '0;
`endif
    resp_rdy = 1'b1;
    @(posedge clk);
    #1 resp_rdy = 1'b0;
  endtask

  logic [31:0] gold [16];

  task automatic gold_partition(input int lo, input int hi, input bit sgn, input bit desc,
                                output int idx);
    logic [31:0] p, t;
    bit b;
    int i;
    p = gold[hi];
    i = lo;
    for (int j = lo; j < hi; j++) begin
      if (desc) b = sgn ? ($signed(gold[j]) > $signed(p)) : (gold[j] > p);
      else      b = sgn ? ($signed(gold[j]) < $signed(p)) : (gold[j] < p);
      if (b) begin
        t = gold[i]; gold[i] = gold[j]; gold[j] = t;
        i++;
      end
    end
    t = gold[i]; gold[i] = gold[hi]; gold[hi] = t;
    idx = i;
  endtask

  logic [IDX_W-1:0] r_idx, r_swp;
  int r_cyc, r_nreq, g_idx, waited;

  initial begin
    reset_n = 1'b0; cmd_val = 1'b0; cmd_base = '0; cmd_lo = '0; cmd_hi = '0;
    cmd_signed = 1'b0; cmd_desc = 1'b0; resp_rdy = 1'b0;
    for (int k = 0; k < 64; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("rst_resp_val", {31'd0, resp_val}, 32'd0);
    check("rst_resp_idx", 32'(resp_idx), 32'd0);
    check("rst_req_val", {31'd0, mem_reqstream_val}, 32'd0);
    check("rst_resp_rdy", {31'd0, mem_respstream_rdy}, 32'd0);
`ifdef LAB2_XCEL_PARTITION_STATS_EN
    check("rst_swaps", 32'(resp_swaps), 32'd0);
`endif
    reset_n = 1'b1;

    // Unsigned ascending: 11 accesses -> 23 cycles.
    load5(3, 7, 1, 5, 4);
    run_cmd(0, 4, 1'b0, 1'b0, r_idx, r_cyc, r_nreq, r_swp);
    check("asc_idx", 32'(r_idx), 2);
    check("asc_cycles", r_cyc, 23);
    check("asc_nreq", r_nreq, 11);
    check5("asc", 3, 1, 4, 5, 7);
`ifdef LAB2_XCEL_PARTITION_STATS_EN
    check("asc_swaps", 32'(r_swp), 2);
`endif

    load5(32'hFFFF_FFFF, 2, 0, 0, 0);
    run_cmd(0, 2, 1'b1, 1'b0, r_idx, r_cyc, r_nreq, r_swp);
    check("sgn_idx", 32'(r_idx), 1);
    check("sgn_cycles", r_cyc, 13);
    check5("sgn", 32'hFFFF_FFFF, 0, 2, 0, 0);

    load5(32'hFFFF_FFFF, 2, 0, 0, 0);
    run_cmd(0, 2, 1'b0, 1'b0, r_idx, r_cyc, r_nreq, r_swp);
    check("uns_idx", 32'(r_idx), 0);
    check5("uns", 0, 2, 32'hFFFF_FFFF, 0, 0);

    // Descending: three swaps, 14 accesses.
    load5(3, 7, 1, 5, 4);
    run_cmd(0, 4, 1'b0, 1'b1, r_idx, r_cyc, r_nreq, r_swp);
    check("desc_idx", 32'(r_idx), 2);
    check("desc_cycles", r_cyc, 29);
    check5("desc", 7, 5, 4, 3, 1);
`ifdef LAB2_XCEL_PARTITION_STATS_EN
    check("desc_swaps", 32'(r_swp), 3);
`endif

    // Every element before pivot: i reaches hi, no swap at all.
    load5(1, 2, 3, 9, 9);
    run_cmd(0, 2, 1'b0, 1'b0, r_idx, r_cyc, r_nreq, r_swp);
    check("noswap_idx", 32'(r_idx), 2);
    check("noswap_cycles", r_cyc, 7);
    check5("noswap", 1, 2, 3, 9, 9);
`ifdef LAB2_XCEL_PARTITION_STATS_EN
    check("noswap_swaps", 32'(r_swp), 0);
`endif

    run_cmd(5, 5, 1'b0, 1'b0, r_idx, r_cyc, r_nreq, r_swp);
    check("eq_idx", 32'(r_idx), 5);
    check("eq_cycles", r_cyc, 1);
    check("eq_nreq", r_nreq, 0);
    run_cmd(6, 2, 1'b0, 1'b0, r_idx, r_cyc, r_nreq, r_swp);
    check("gt_idx", 32'(r_idx), 6);
    check("gt_cycles", r_cyc, 1);
    check("gt_nreq", r_nreq, 0);

    // hi = all-ones; model maps indices 0xFFFE/0xFFFF to words 62/63.
    mem[62] = 9; mem[63] = 4;
    run_cmd(16'hFFFE, 16'hFFFF, 1'b0, 1'b0, r_idx, r_cyc, r_nreq, r_swp);
    check("top_idx", 32'(r_idx), 32'hFFFE);
    check("top_cycles", r_cyc, 11);
    check("top_m62", mem[62], 4);
    check("top_m63", mem[63], 9);

    // Random array under random stalls, signed ascending.
    for (int k = 0; k < 16; k++) begin
      mem[k]  = (k % 3 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      gold[k] = mem[k];
    end
    gold_partition(0, 15, 1'b1, 1'b0, g_idx);
    stall_en = 1'b1;
    run_cmd(0, 15, 1'b1, 1'b0, r_idx, r_cyc, r_nreq, r_swp);
    stall_en = 1'b0;
    check("rnd_idx", 32'(r_idx), 32'(g_idx));
    for (int k = 0; k < 16; k++) check($sformatf("rnd_m%0d", k), mem[k], gold[k]);
    check("rnd_msg_stable", stab_viol, 0);

    // Reset during WR_I, then a fresh command.
    load5(3, 7, 1, 5, 4);
    @(negedge clk);
    cmd_base = 32'h1000; cmd_lo = 0; cmd_hi = 4; cmd_signed = 1'b0; cmd_desc = 1'b0;
    cmd_val = 1'b1;
    @(posedge clk);
    #1 cmd_val = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(mem_reqstream_val && mem_reqstream_msg.type_ == MEM_TYPE_WRITE) && waited < 200);
    check("wr_i_reached", {31'd0, mem_reqstream_val}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("abort_resp_val", {31'd0, resp_val}, 32'd0);
    check("abort_resp_idx", 32'(resp_idx), 32'd0);
    check("abort_req_val", {31'd0, mem_reqstream_val}, 32'd0);
    check("abort_resp_rdy", {31'd0, mem_respstream_rdy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    load5(3, 7, 1, 5, 4);
    run_cmd(0, 4, 1'b0, 1'b0, r_idx, r_cyc, r_nreq, r_swp);
    check("post_rst_idx", 32'(r_idx), 2);
    check5("post_rst", 3, 1, 4, 5, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lab2_xcel_partition_engine.md
# lab2_xcel_partition_engine

In-place quicksort partition engine (Lomuto scheme) for 32-bit words resident in memory, driven by a command/response handshake. It is the parametrised successor to the single-mode partition stage: it takes configurable index width, signed/unsigned compare, ascending/descending order, and an arbitrary `[lo, hi]` sub-range. It sits between the sorting accelerator control FSM (cmd/resp side) and the accelerator memory port (`mem_req_4B_t`/`mem_resp_4B_t` streams).

## Interface
- `IDX_W`, default 16: width of element indices `lo`, `hi` and the result index.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_val` / `cmd_rdy`, in / out, 1 each: command handshake; transfer when both high.
- `cmd_base` in 32: byte address of element 0.
- `cmd_lo`, `cmd_hi` in IDX_W: inclusive sub-range; pivot is `a[hi]`.
- `cmd_signed` in 1: 1 = two's-complement compare, 0 = unsigned.
- `cmd_desc` in 1: 0 = elements strictly less than pivot go left; 1 = strictly greater go left.
- `resp_val` / `resp_rdy`, out / in, 1 each: result handshake.
- `resp_idx` out IDX_W: final pivot position.
- `resp_swaps` out IDX_W: present only under `LAB2_XCEL_PARTITION_STATS_EN`.
- `mem_reqstream_msg` out `mem_req_4B_t`, `mem_reqstream_val` out 1, `mem_reqstream_rdy` in 1.
- `mem_respstream_msg` in `mem_resp_4B_t`, `mem_respstream_val` in 1, `mem_respstream_rdy` out 1.

## Operation
- Address of element k = `cmd_base + (k << 2)`, mod 2^32. Requests use len 0 (4 B) and opaque 0; reads use type read, writes type write with data.
- Algorithm: `p = a[hi]; i = lo; for j = lo..hi-1: if before(a[j], p) { if i != j: swap a[i], a[j]; i++ }; if i != hi: swap a[i], a[hi]; return i`.
- Swap sequence: read `a[i]`, write `a[i] = a[j]`, write `a[j] = old a[i]`. The final swap writes `a[i] = p` and `a[hi] = old a[i]`.
- `a[j]` and `p` are held in registers; memory is never re-read for them.
- States: IDLE, RD_P, RD_J, RD_I, WR_I, WR_J, RESP. Each memory state has an issue phase and a wait phase; write responses are awaited before the next request.
- Transitions:
  - IDLE → RD_P on cmd, or → RESP directly if `lo >= hi` (result `lo`, no memory traffic).
  - RD_P → RD_J.
  - RD_J → RD_I if before and `i != j`. Otherwise → RD_J (next j), or → the final swap / RESP when `j == hi`.
  - RD_I → WR_I → WR_J → RD_J/RESP.
  - RESP → IDLE on `resp_rdy`.
- Index arithmetic is IDX_W bits. `hi` of all-ones is legal: the loop terminates on `j == hi` compare, not on overflow.
- Swap counter counts executed swaps, including the final swap when `i != hi`.

## Timing
- Reset values: `cmd_rdy=1`, `resp_val=0`, `resp_idx=0`, `mem_reqstream_val=0`, `mem_respstream_rdy=0`, state IDLE, swaps 0.
- `cmd_rdy` is high only in IDLE. `resp_val` is high only in RESP, with `resp_idx` stable until accepted.
- At most one outstanding memory request. `mem_reqstream_val` and msg are held stable until `rdy`. `mem_respstream_rdy` is high only in wait phases.
- Request issue is the earliest cycle after the previous response is accepted. With a 1-cycle memory, each access costs 2 cycles. Command-to-resp_val = 2 × (access count) + 1 cycles; for `lo >= hi` it is 1 cycle.
- Asynchronous reset mid-operation aborts immediately to IDLE. The memory system must be reset together with this block, because a stale response is not tolerated.

## Configuration
- `LAB2_XCEL_PARTITION_STATS_EN`:
  - Defined: the swap counter and `resp_swaps` port exist. The counter clears on command accept and is valid with `resp_val`.
  - Undefined: neither the port nor the counter exists; all other behaviour is identical.

## Test plan
- Unsigned ascending, base 0x1000, `[3,7,1,5,4]`, lo 0, hi 4 → memory `[3,1,4,5,7]`, `resp_idx` 2, swaps 2.
- Signed ascending, `[0xFFFFFFFF,2,0]`, lo 0, hi 2 → `[0xFFFFFFFF,0,2]`, idx 1. The same data unsigned → `[0,2,0xFFFFFFFF]`, idx 0.
- Descending, `[3,7,1,5,4]` → `[7,5,4,3,1]`? No: the Lomuto result is `[7,5,4,3,1]` only if the trace matches. The bench checks the trace: j0 3 no, j1 7 swap(0,1) → `[7,3,1,5,4]` i1, j3 5 swap(1,3) → `[7,5,1,3,4]` i2, final swap(2,4) → `[7,5,4,3,1]`, idx 2.
- `lo == hi == 5` and `lo > hi` → resp idx = lo after 1 cycle, with zero memory requests.
- Random `mem_reqstream_rdy`/`mem_respstream_val` stalls on a 16-element random array: the result matches the golden model, and msg is stable while `val && !rdy`.
- Assert `reset_n` low during WR_I, then issue a fresh command: outputs return to reset values asynchronously, and the next partition completes correctly.
